io_mem_unit: RTL

Memory stage of the single-cycle processor: consumes the ALU result as a byte address plus the second register operand as store data, and returns load data to the register write-back mux. It holds a word-addressed data RAM and the memory-mapped I/O registers for HEX, LEDR, KEY and SW. KEY and SW inputs are synchronised, and KEY presses can be captured as sticky events.

---
 rtl/io_mem_pkg.sv | 21 ++
 rtl/io_mem_unit_if.sv | 26 ++
 rtl/io_input_sync.sv | 22 ++
 rtl/io_mem_unit.sv | 111 +++++++++++
 4 files changed

// File: rtl/io_mem_pkg.sv
// Shared I/O map constants, board widths and address helper for the memory stage.
package io_mem_pkg;

    localparam logic [31:0] ADDR_HEX  = 32'hF000_0000;
    localparam logic [31:0] ADDR_LEDR = 32'hF000_0004;
    localparam logic [31:0] ADDR_KEY  = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW   = 32'hF000_0014;

    localparam logic [3:0] IO_REGION = 4'hF;

    localparam int LEDR_BITS = 10;
    localparam int SW_BITS   = 10;
    localparam int KEY_BITS  = 4;
    localparam int HEX_BITS  = 16;

    // Word address of a byte address; the two byte-select bits never matter.
    function automatic logic [29:0] io_word(input logic [31:0] a);
        return a[31:2];
    endfunction

endpackage

// File: rtl/io_mem_unit_if.sv
// Processor-to-memory-stage bus: address, store data, strobes and load data.
interface io_mem_unit_if #(
    parameter int DBITS = 32
);
    logic             mem_wrt_en;
    logic             mem_rd_en;
    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] wr_data;
    logic [DBITS-1:0] rd_data;

    modport master (
        output mem_wrt_en,
        output mem_rd_en,
        output addr,
        output wr_data,
        input  rd_data
    );

    modport slave (
        input  mem_wrt_en,
        input  mem_rd_en,
        input  addr,
        input  wr_data,
        output rd_data
    );
endinterface

// File: rtl/io_input_sync.sv
// Two-flop synchroniser for asynchronous board inputs, synchronous reset to 0.
// Latency 2 edges from d to q; no flow control.
module io_input_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/io_mem_unit.sv
// Memory stage: word RAM plus HEX/LEDR/KEY/SW registers; loads combinational, stores on the edge.
// Optional sticky KEY press events are built when IO_KEY_EVENT_EN is defined; no backpressure.
module io_mem_unit
    import io_mem_pkg::*;
#(
    parameter int    DBITS          = 32,
    parameter int    DMEM_ADDR_BITS = 11,
    parameter string DMEM_INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 reset,
    io_mem_unit_if.slave         mem,
    input  logic [SW_BITS-1:0]   sw,
    input  logic [KEY_BITS-1:0]  key,
    output logic [LEDR_BITS-1:0] ledr,
    output logic [HEX_BITS-1:0]  hex
);
    localparam int DMEM_WORDS = 1 << DMEM_ADDR_BITS;

    logic [DBITS-1:0] dmem [0:DMEM_WORDS-1];

    logic [SW_BITS-1:0]        sw_sync;
    logic [KEY_BITS-1:0]       key_sync;
    logic [KEY_BITS-1:0]       key_prev;
    logic [KEY_BITS-1:0]       key_bits;
    logic [HEX_BITS-1:0]       hex_q;
    logic [LEDR_BITS-1:0]      ledr_q;
    logic [DMEM_ADDR_BITS-1:0] ram_idx;
    logic [29:0]               word;
    logic                      io_sel;
    logic [DBITS-1:0]          rd_c;

    io_input_sync #(.W(SW_BITS)) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw),
        .q     (sw_sync)
    );

    // Keys are active-low on the board; sync the inverted level so 1 = pressed.
    io_input_sync #(.W(KEY_BITS)) u_key_sync (
        .clk   (clk),
        .reset (reset),
        .d     (~key),
        .q     (key_sync)
    );

    always_ff @(posedge clk) begin
        if (reset) key_prev <= '0;
        else       key_prev <= key_sync;
    end

    assign io_sel  = (mem.addr[DBITS-1 -: 4] == IO_REGION);
    assign word    = io_word(mem.addr);
    assign ram_idx = mem.addr[DMEM_ADDR_BITS+1:2];

`ifdef IO_KEY_EVENT_EN
    logic [KEY_BITS-1:0] key_evt;
    logic                key_clr;

    assign key_clr = mem.mem_rd_en && io_sel && (word == io_word(ADDR_KEY));

    // A fresh press edge on the clearing cycle is ORed in after the clear, so it survives.
    always_ff @(posedge clk) begin
        if (reset) key_evt <= '0;
        else       key_evt <= (key_clr ? '0 : key_evt) | (key_sync & ~key_prev);
    end

    assign key_bits = key_evt;
`else
    assign key_bits = key_sync;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_q  <= '0;
            ledr_q <= '0;
        end else if (mem.mem_wrt_en && io_sel) begin
            if (word == io_word(ADDR_HEX))  hex_q  <= mem.wr_data[HEX_BITS-1:0];
            if (word == io_word(ADDR_LEDR)) ledr_q <= mem.wr_data[LEDR_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && mem.mem_wrt_en && !io_sel) dmem[ram_idx] <= mem.wr_data;
    end

    always_comb begin
        rd_c = '0;
        if (io_sel) begin
            if (word == io_word(ADDR_HEX))       rd_c[HEX_BITS-1:0]  = hex_q;
            else if (word == io_word(ADDR_LEDR)) rd_c[LEDR_BITS-1:0] = ledr_q;
            else if (word == io_word(ADDR_KEY))  rd_c[KEY_BITS-1:0]  = key_bits;
            else if (word == io_word(ADDR_SW))   rd_c[SW_BITS-1:0]   = sw_sync;
        end else begin
            rd_c = dmem[ram_idx];
        end
    end

    assign mem.rd_data = rd_c;
    assign hex         = hex_q;
    assign ledr        = ledr_q;

    logic unused_bits;
`ifdef IO_KEY_EVENT_EN
    assign unused_bits = ^mem.addr[1:0];
`else
    assign unused_bits = ^{mem.addr[1:0], mem.mem_rd_en, key_prev};
`endif

endmodule
